fcvt_f2i_stage: RTL and testbench
=================================

Name: fcvt_f2i_stage

Overview:
- Pipelined, handshaked execution stage for FCVT.W.S and FCVT.WU.S in the rv32imf FPU.
- Accepts an operand from FPU issue and produces a RISC-V-compliant 32-bit integer result plus fflags.
- Result and flags go downstream to integer writeback.
- Two register stages: unpack/align, then round/saturate. Full valid/ready backpressure and a flush input for pipeline kills.

Parameters:
TAG_W, 5, width of the destination-register tag carried alongside the operation
FLAGS_W, 5, fflags width {NV,DZ,OF,UF,NX}

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of all in-flight operations
in_valid  input  1  operation offered
in_ready  output  1  stage can accept
in_op_a  input  32  single-precision operand
in_rm  input  3  instruction rounding mode (7 = dynamic)
in_frm  input  3  fcsr.frm, used when in_rm = 7
in_unsigned  input  1  1 = FCVT.WU.S, 0 = FCVT.W.S
in_tag  input  TAG_W  destination tag
out_valid  output  1  result available
out_ready  input  1  downstream accepts
out_result  output  32  integer result
out_fflags  output  FLAGS_W  exception flags, only NV and NX ever set
out_tag  output  TAG_W  tag of result
out_illegal_rm  output  1  effective rm was 5 or 6

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high.
- Reset values: s1_valid = 0, s2_valid = 0, out_valid = 0, out_result = 0, out_fflags = 0, out_tag = 0, out_illegal_rm = 0.
- Handshake and advance:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv
  - A transfer occurs on in_valid && in_ready.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- out_* stay stable while out_valid && !out_ready.
- S1 (unpack):
  - Resolve effective rm: in_rm, or in_frm when in_rm = 7.
  - Decode class: NaN, inf, zero, normal; subnormals are treated as magnitude < 1.
  - Compute unbiased exponent e = exp - 127.
  - Align {1,man} into a 32-bit integer part plus G, R, S (S = OR of all remaining shifted-out bits).
  - Shift-out is saturated: e < -2 gives integer 0, G = 0, R = 0, S = 1 for nonzero input.
  - Register sign, class, integer part, G, R, S, rm, unsigned, tag.
- S2 (round/saturate):
  - inexact = G | R | S.
  - Increment magnitude by rounding mode:
    - RNE: G & (R | S | lsb)
    - RTZ: never
    - RDN: sign & inexact
    - RUP: !sign & inexact
    - RMM: G
  - Rounding uses a 33-bit magnitude sum so carry-out is detected.
  - Signed range [-2^31, 2^31-1]; unsigned range [0, 2^32-1], checked after rounding.
  - Out of range → saturate and set NV, clear NX.
  - Negative values that round to magnitude 0 for WU → result 0 with NX only, no NV.
  - NaN → 0x7FFFFFFF (W) or 0xFFFFFFFF (WU), NV.
  - +inf → max, NV.
  - -inf → 0x80000000 (W) or 0 (WU), NV.
  - Signed result = sign ? -mag : mag.
  - NX set only for in-range inexact results.
- Illegal rm (5 or 6): out_result = 0, out_fflags = 0, out_illegal_rm = 1. The op still flows through so the tag retires.
- Flush:
  - Clears s1_valid and s2_valid next edge, regardless of out_ready.
  - A same-cycle in_valid is dropped.
  - Flush has priority over accept and over output transfer.
- Reset mid-operation: all in-flight ops are discarded and no output is produced.
- Simultaneous out transfer and new accept: the pipeline shifts, no bubble inserted.

Decomposition:
- Package fpu_cvt_pkg:
  - rm encodings (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4, DYN=7)
  - fflags bit indices
  - saturation constants: INT_MAX, INT_MIN, UINT_MAX
  - fp class enum
- One sub-module: fcvt_f2i_round, combinational S2 round/saturate logic, so it can be unit-tested standalone.

Test Plan:
1. 0x40200000 (2.5), W: rm=RNE → 2, fflags 0x01; rm=RUP → 3, 0x01; rm=RMM → 3, 0x01; rm=RTZ → 2, 0x01.
2. 0xBFC00000 (-1.5), W, RNE → 0xFFFFFFFE, fflags 0x01; same operand, WU → 0, fflags 0x10.
3. 0x4F32D05E (3e9): W → 0x7FFFFFFF, fflags 0x10; WU → 0xB2D05E00, fflags 0x00.
4. Special operands, W then WU:
   - 0x7FC00000 (NaN) → 0x7FFFFFFF / 0xFFFFFFFF, NV.
   - 0xFF800000 (-inf) → 0x80000000 / 0, NV.
   - 0xBE99999A (-0.3), WU, RNE → 0, fflags 0x01.
5. rm=7 with frm=3 on 2.5 → 3. Backpressure: out_ready=0 while 3 ops are offered → 2 accepted, in_ready falls, outputs held stable. Releasing out_ready drains in order with tags preserved.
6. Flush while 2 ops are in flight and out_ready=0 → out_valid=0 next cycle, no stale output later. Reset asserted mid-stream → same result; all outputs read 0 after the reset edge.

Source files
------------

// File: rtl/fpu_cvt_pkg.sv
// Shared definitions for the FPU float-to-integer conversion path.
// Holds the rounding-mode encodings, fflags bit positions, integer
// saturation constants and the operand class enum used between the
// unpack stage and the round/saturate logic.
package fpu_cvt_pkg;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;
   localparam logic [2:0] RM_DYN = 3'd7;

   // Bit positions inside fflags {NV,DZ,OF,UF,NX}
   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      FP_ZERO   = 2'd0,
      FP_NORMAL = 2'd1,
      FP_INF    = 2'd2,
      FP_NAN    = 2'd3
   } fpClass_e;

   // Encodings 5 and 6 are reserved and make the instruction illegal
   function automatic logic isIllegalRm(input logic [2:0] rm);
      return (rm == 3'd5) || (rm == 3'd6);
   endfunction

endpackage

// File: rtl/fcvt_f2i_round.sv
// Combinational round/saturate logic for FCVT.W.S / FCVT.WU.S.
// Takes the aligned magnitude (integer part plus guard, round, sticky)
// and produces the final 32-bit integer and fflags.
// Ports:
//   i_sign, i_class, i_big   operand sign, class, magnitude >= 2^32
//   i_intPart, i_guard,
//   i_round, i_sticky        aligned magnitude
//   i_rm                     effective rounding mode
//   i_unsigned               1 = WU, 0 = W
//   o_result, o_fflags       integer result and flags (NV/NX only)
//   o_illegalRm              effective rm was reserved
module fcvt_f2i_round
   import fpu_cvt_pkg::*;
#(
   parameter int FLAGS_W = 5
) (
   input  logic               i_sign,
   input  fpClass_e           i_class,
   input  logic               i_big,
   input  logic [31:0]        i_intPart,
   input  logic               i_guard,
   input  logic               i_round,
   input  logic               i_sticky,
   input  logic [2:0]         i_rm,
   input  logic               i_unsigned,
   output logic [31:0]        o_result,
   output logic [FLAGS_W-1:0] o_fflags,
   output logic               o_illegalRm
);

   logic        w_inexact;
   logic        w_inc;
   logic [32:0] w_mag;
   logic        w_nv;
   logic        w_nx;
   logic        w_illegal;

   // Round increment decision; an effective rm of 7 (frm itself dynamic)
   // has no defined meaning, so it falls back to round-to-nearest-even.
   always_comb begin
      w_inexact = i_guard | i_round | i_sticky;
      w_inc     = 1'b0;
      case (i_rm)
         RM_RNE:  w_inc = i_guard & (i_round | i_sticky | i_intPart[0]);
         RM_RTZ:  w_inc = 1'b0;
         RM_RDN:  w_inc = i_sign & w_inexact;
         RM_RUP:  w_inc = ~i_sign & w_inexact;
         RM_RMM:  w_inc = i_guard;
         default: w_inc = i_guard & (i_round | i_sticky | i_intPart[0]);
      endcase
      // 33 bits so a carry out of 0xFFFFFFFF is visible as overflow
      w_mag = {1'b0, i_intPart} + {32'd0, w_inc};
   end

   // Range check after rounding, special operands, and saturation.
   // NX is only reported when the rounded value is actually representable.
   always_comb begin
      w_illegal = isIllegalRm(i_rm);
      o_result  = 32'd0;
      w_nv      = 1'b0;
      w_nx      = 1'b0;
      if (!w_illegal) begin
         case (i_class)
            FP_NAN: begin
               o_result = i_unsigned ? UINT_MAX : INT_MAX;
               w_nv     = 1'b1;
            end
            FP_INF: begin
               if (i_sign) o_result = i_unsigned ? 32'd0 : INT_MIN;
               else        o_result = i_unsigned ? UINT_MAX : INT_MAX;
               w_nv = 1'b1;
            end
            FP_ZERO: begin
               o_result = 32'd0;
            end
            default: begin
               if (i_unsigned) begin
                  if (i_sign) begin
                     // A small negative that rounds to zero is merely inexact
                     if (!i_big && (w_mag == 33'd0)) begin
                        o_result = 32'd0;
                        w_nx     = w_inexact;
                     end else begin
                        o_result = 32'd0;
                        w_nv     = 1'b1;
                     end
                  end else if (i_big || w_mag[32]) begin
                     o_result = UINT_MAX;
                     w_nv     = 1'b1;
                  end else begin
                     o_result = w_mag[31:0];
                     w_nx     = w_inexact;
                  end
               end else begin
                  if (i_sign) begin
                     if (!i_big && (w_mag <= 33'h0_8000_0000)) begin
                        o_result = 32'd0 - w_mag[31:0];
                        w_nx     = w_inexact;
                     end else begin
                        o_result = INT_MIN;
                        w_nv     = 1'b1;
                     end
                  end else if (!i_big && (w_mag <= 33'h0_7FFF_FFFF)) begin
                     o_result = w_mag[31:0];
                     w_nx     = w_inexact;
                  end else begin
                     o_result = INT_MAX;
                     w_nv     = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Flag vector assembly; conversion never divides, overflows into
   // infinity or underflows, so only NV and NX can be raised.
   always_comb begin
      o_fflags          = '0;
      o_fflags[FLAG_NV] = w_nv;
      o_fflags[FLAG_DZ] = 1'b0;
      o_fflags[FLAG_OF] = 1'b0;
      o_fflags[FLAG_UF] = 1'b0;
      o_fflags[FLAG_NX] = w_nx;
      o_illegalRm       = w_illegal;
   end

endmodule

// File: rtl/fcvt_f2i_stage.sv
// Two-stage pipelined FCVT.W.S / FCVT.WU.S execution stage.
// Stage 1 unpacks the single-precision operand and aligns it into a
// 32-bit integer part with guard/round/sticky; stage 2 rounds, saturates
// and registers the result for integer writeback.
// Ports:
//   clk, reset, flush            clock, sync active-high reset, pipeline kill
//   in_valid/in_ready            issue handshake
//   in_op_a, in_rm, in_frm,
//   in_unsigned, in_tag          operation payload
//   out_valid/out_ready          writeback handshake
//   out_result, out_fflags,
//   out_tag, out_illegal_rm      registered result payload
module fcvt_f2i_stage
   import fpu_cvt_pkg::*;
#(
   parameter int TAG_W   = 5,
   parameter int FLAGS_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_op_a,
   input  logic [2:0]         in_rm,
   input  logic [2:0]         in_frm,
   input  logic               in_unsigned,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_result,
   output logic [FLAGS_W-1:0] out_fflags,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_illegal_rm
);

   logic               r_s1Valid;
   logic               r_s1Sign;
   fpClass_e           r_s1Class;
   logic               r_s1Big;
   logic [31:0]        r_s1Int;
   logic               r_s1G;
   logic               r_s1R;
   logic               r_s1S;
   logic [2:0]         r_s1Rm;
   logic               r_s1Unsigned;
   logic [TAG_W-1:0]   r_s1Tag;

   logic               r_s2Valid;
   logic [31:0]        r_outResult;
   logic [FLAGS_W-1:0] r_outFflags;
   logic [TAG_W-1:0]   r_outTag;
   logic               r_outIllegal;

   logic               w_s1Adv;
   logic               w_s2Adv;
   logic               w_accept;
   logic [7:0]         w_expField;
   logic [22:0]        w_man;
   logic [2:0]         w_effRm;
   logic [7:0]         w_shamt;
   logic [56:0]        w_wide;
   fpClass_e           w_class;
   logic               w_big;
   logic [31:0]        w_int;
   logic               w_g;
   logic               w_r;
   logic               w_s;
   logic [31:0]        w_rndResult;
   logic [FLAGS_W-1:0] w_rndFflags;
   logic               w_rndIllegal;

   // Each stage moves when its successor has room or is draining
   always_comb begin
      w_s2Adv  = !r_s2Valid || out_ready;
      w_s1Adv  = !r_s1Valid || w_s2Adv;
      in_ready = w_s1Adv;
      w_accept = in_valid && w_s1Adv && !flush;
   end

   // Unpack and align. The value is scaled by 2^25 so that bits [56:25]
   // hold the integer part and [24:0] the fraction; the shift amount is
   // e+2 = exp-125, valid for unbiased exponents -2..31. Anything smaller
   // only contributes sticky, anything larger cannot fit in 32 bits.
   always_comb begin
      w_expField = in_op_a[30:23];
      w_man      = in_op_a[22:0];
      w_effRm    = (in_rm == RM_DYN) ? in_frm : in_rm;
      w_shamt    = w_expField - 8'd125;
      w_wide     = {33'd0, 1'b1, w_man} << w_shamt;
      w_class    = FP_NORMAL;
      w_big      = 1'b0;
      w_int      = 32'd0;
      w_g        = 1'b0;
      w_r        = 1'b0;
      w_s        = 1'b0;
      if (w_expField == 8'hFF) begin
         w_class = (w_man != 23'd0) ? FP_NAN : FP_INF;
      end else if (w_expField == 8'h00) begin
         // Subnormals are far below 1 and only contribute sticky
         if (w_man == 23'd0) w_class = FP_ZERO;
         else                w_s     = 1'b1;
      end else if (w_expField > 8'd158) begin
         w_big = 1'b1;
      end else if (w_expField < 8'd125) begin
         w_s = 1'b1;
      end else begin
         w_int = w_wide[56:25];
         w_g   = w_wide[24];
         w_r   = w_wide[23];
         w_s   = |w_wide[22:0];
      end
   end

   fcvt_f2i_round #(
      .FLAGS_W (FLAGS_W)
   ) u_round (
      .i_sign      (r_s1Sign),
      .i_class     (r_s1Class),
      .i_big       (r_s1Big),
      .i_intPart   (r_s1Int),
      .i_guard     (r_s1G),
      .i_round     (r_s1R),
      .i_sticky    (r_s1S),
      .i_rm        (r_s1Rm),
      .i_unsigned  (r_s1Unsigned),
      .o_result    (w_rndResult),
      .o_fflags    (w_rndFflags),
      .o_illegalRm (w_rndIllegal)
   );

   // Pipeline registers. Flush kills both valid bits and blocks any
   // same-cycle load; output payload only changes when stage 2 advances
   // with a real op, so it stays put while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1Valid    <= 1'b0;
         r_s1Sign     <= 1'b0;
         r_s1Class    <= FP_ZERO;
         r_s1Big      <= 1'b0;
         r_s1Int      <= 32'd0;
         r_s1G        <= 1'b0;
         r_s1R        <= 1'b0;
         r_s1S        <= 1'b0;
         r_s1Rm       <= RM_RNE;
         r_s1Unsigned <= 1'b0;
         r_s1Tag      <= '0;
         r_s2Valid    <= 1'b0;
         r_outResult  <= 32'd0;
         r_outFflags  <= '0;
         r_outTag     <= '0;
         r_outIllegal <= 1'b0;
      end else begin
         if (flush) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
         end else begin
            if (w_s1Adv) r_s1Valid <= in_valid;
            if (w_s2Adv) r_s2Valid <= r_s1Valid;
         end
         if (w_accept) begin
            r_s1Sign     <= in_op_a[31];
            r_s1Class    <= w_class;
            r_s1Big      <= w_big;
            r_s1Int      <= w_int;
            r_s1G        <= w_g;
            r_s1R        <= w_r;
            r_s1S        <= w_s;
            r_s1Rm       <= w_effRm;
            r_s1Unsigned <= in_unsigned;
            r_s1Tag      <= in_tag;
         end
         if (w_s2Adv && r_s1Valid && !flush) begin
            r_outResult  <= w_rndResult;
            r_outFflags  <= w_rndFflags;
            r_outTag     <= r_s1Tag;
            r_outIllegal <= w_rndIllegal;
         end
      end
   end

   assign out_valid      = r_s2Valid;
   assign out_result     = r_outResult;
   assign out_fflags     = r_outFflags;
   assign out_tag        = r_outTag;
   assign out_illegal_rm = r_outIllegal;

endmodule

// File: tb/tb_fcvt_f2i_stage.sv
// Self-checking bench for fcvt_f2i_stage: a table of single-op vectors
// with hand-computed results, then hand-written backpressure, flush and
// mid-stream reset sequences.
module tb_fcvt_f2i_stage;
   import fpu_cvt_pkg::*;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_op_a;
   logic [2:0]  in_rm;
   logic [2:0]  in_frm;
   logic        in_unsigned;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_fflags;
   logic [4:0]  out_tag;
   logic        out_illegal_rm;

   int checks;
   int errors;

   typedef struct {
      logic [31:0] opA;
      logic [2:0]  rm;
      logic [2:0]  frm;
      logic        uns;
      logic [31:0] expResult;
      logic [4:0]  expFlags;
      logic        expIllegal;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs [NVEC];

   fcvt_f2i_stage #(
      .TAG_W   (5),
      .FLAGS_W (5)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_op_a        (in_op_a),
      .in_rm          (in_rm),
      .in_frm         (in_frm),
      .in_unsigned    (in_unsigned),
      .in_tag         (in_tag),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_result     (out_result),
      .out_fflags     (out_fflags),
      .out_tag        (out_tag),
      .out_illegal_rm (out_illegal_rm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle away from the active edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic setOp(input logic [31:0] a, input logic [2:0] rm, input logic [2:0] frm,
                        input logic uns, input logic [4:0] tag);
      in_op_a     = a;
      in_rm       = rm;
      in_frm      = frm;
      in_unsigned = uns;
      in_tag      = tag;
   endtask

   // Push one op through an otherwise idle pipe and check result and latency
   task automatic applyStimulus(input int idx);
      int lat;
      logic [4:0] tag;
      tag = 5'(idx + 3);
      setOp(vecs[idx].opA, vecs[idx].rm, vecs[idx].frm, vecs[idx].uns, tag);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 6) begin
         step();
         lat++;
      end
      checkOutput($sformatf("vec%0d_latency", idx), 64'(lat), 64'd2);
      checkOutput($sformatf("vec%0d_payload", idx),
                  {21'd0, out_valid, out_illegal_rm, out_fflags, out_tag, out_result},
                  {21'd0, 1'b1, vecs[idx].expIllegal, vecs[idx].expFlags, tag, vecs[idx].expResult});
      step();
   endtask

   task automatic fillVectors();
      vecs[0]  = '{32'h4020_0000, RM_RNE, 3'd0,   1'b0, 32'd2,          5'h01, 1'b0};
      vecs[1]  = '{32'h4020_0000, RM_RUP, 3'd0,   1'b0, 32'd3,          5'h01, 1'b0};
      vecs[2]  = '{32'h4020_0000, RM_RMM, 3'd0,   1'b0, 32'd3,          5'h01, 1'b0};
      vecs[3]  = '{32'h4020_0000, RM_RTZ, 3'd0,   1'b0, 32'd2,          5'h01, 1'b0};
      vecs[4]  = '{32'hBFC0_0000, RM_RNE, 3'd0,   1'b0, 32'hFFFF_FFFE,  5'h01, 1'b0};
      vecs[5]  = '{32'hBFC0_0000, RM_RNE, 3'd0,   1'b1, 32'd0,          5'h10, 1'b0};
      vecs[6]  = '{32'h4F32_D05E, RM_RNE, 3'd0,   1'b0, 32'h7FFF_FFFF,  5'h10, 1'b0};
      vecs[7]  = '{32'h4F32_D05E, RM_RNE, 3'd0,   1'b1, 32'hB2D0_5E00,  5'h00, 1'b0};
      vecs[8]  = '{32'h7FC0_0000, RM_RNE, 3'd0,   1'b0, 32'h7FFF_FFFF,  5'h10, 1'b0};
      vecs[9]  = '{32'h7FC0_0000, RM_RNE, 3'd0,   1'b1, 32'hFFFF_FFFF,  5'h10, 1'b0};
      vecs[10] = '{32'hFF80_0000, RM_RNE, 3'd0,   1'b0, 32'h8000_0000,  5'h10, 1'b0};
      vecs[11] = '{32'hFF80_0000, RM_RNE, 3'd0,   1'b1, 32'd0,          5'h10, 1'b0};
      vecs[12] = '{32'hBE99_999A, RM_RNE, 3'd0,   1'b1, 32'd0,          5'h01, 1'b0};
      vecs[13] = '{32'h4020_0000, RM_DYN, RM_RUP, 1'b0, 32'd3,          5'h01, 1'b0};
      vecs[14] = '{32'h4020_0000, 3'd5,   3'd0,   1'b0, 32'd0,          5'h00, 1'b1};
      vecs[15] = '{32'h7F80_0000, RM_RNE, 3'd0,   1'b0, 32'h7FFF_FFFF,  5'h10, 1'b0};
      vecs[16] = '{32'hCF00_0000, RM_RNE, 3'd0,   1'b0, 32'h8000_0000,  5'h00, 1'b0};
      vecs[17] = '{32'h4F80_0000, RM_RNE, 3'd0,   1'b1, 32'hFFFF_FFFF,  5'h10, 1'b0};
      vecs[18] = '{32'h0000_0000, RM_RNE, 3'd0,   1'b0, 32'd0,          5'h00, 1'b0};
      vecs[19] = '{32'h3F00_0000, RM_RNE, 3'd0,   1'b0, 32'd0,          5'h01, 1'b0};
      vecs[20] = '{32'h3F00_0000, RM_RUP, 3'd0,   1'b0, 32'd1,          5'h01, 1'b0};
      vecs[21] = '{32'h4EFF_FFFF, RM_RNE, 3'd0,   1'b0, 32'h7FFF_FF80,  5'h00, 1'b0};
      vecs[22] = '{32'hC020_0000, RM_RDN, 3'd0,   1'b0, 32'hFFFF_FFFD,  5'h01, 1'b0};
      vecs[23] = '{32'h0000_0001, RM_RUP, 3'd0,   1'b0, 32'd1,          5'h01, 1'b0};
   endtask

   // Stimulus and sequences
   initial begin
      int got;
      logic acc;
      logic sawOut;
      logic [4:0]  gotTag [3];
      logic [31:0] gotRes [3];

      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      flush       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      setOp(32'd0, RM_RNE, 3'd0, 1'b0, 5'd0);
      fillVectors();
      step();
      step();
      reset = 1'b0;
      #1;

      checkOutput("reset_out_valid",   64'(out_valid),      64'd0);
      checkOutput("reset_out_result",  64'(out_result),     64'd0);
      checkOutput("reset_out_fflags",  64'(out_fflags),     64'd0);
      checkOutput("reset_out_tag",     64'(out_tag),        64'd0);
      checkOutput("reset_out_illegal", 64'(out_illegal_rm), 64'd0);
      checkOutput("reset_in_ready",    64'(in_ready),       64'd1);

      for (int i = 0; i < NVEC; i++) applyStimulus(i);

      // Backpressure: three ops offered with the sink stalled
      out_ready = 1'b0;
      setOp(32'h4020_0000, RM_RNE, 3'd0, 1'b0, 5'd1);
      in_valid = 1'b1;
      step();
      setOp(32'h3F80_0000, RM_RNE, 3'd0, 1'b0, 5'd2);
      step();
      setOp(32'h4F32_D05E, RM_RNE, 3'd0, 1'b1, 5'd3);
      step();
      checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
      checkOutput("bp_out_first", {31'd0, out_valid, 27'd0, out_tag, 32'd0} | 64'(out_result),
                  {31'd0, 1'b1, 27'd0, 5'd1, 32'd0} | 64'd2);
      step();
      step();
      checkOutput("bp_out_held", {31'd0, out_valid, 27'd0, out_tag, 32'd0} | 64'(out_result),
                  {31'd0, 1'b1, 27'd0, 5'd1, 32'd0} | 64'd2);
      checkOutput("bp_in_ready_held", 64'(in_ready), 64'd0);

      out_ready = 1'b1;
      #1;
      got = 0;
      for (int c = 0; c < 10 && got < 3; c++) begin
         if (out_valid) begin
            gotTag[got] = out_tag;
            gotRes[got] = out_result;
            got++;
         end
         acc = in_valid && in_ready;
         step();
         if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checkOutput("bp_drain_count", 64'(got), 64'd3);
      if (got == 3) begin
         checkOutput("bp_drain0", {27'd0, gotTag[0], gotRes[0]}, {27'd0, 5'd1, 32'd2});
         checkOutput("bp_drain1", {27'd0, gotTag[1], gotRes[1]}, {27'd0, 5'd2, 32'd1});
         checkOutput("bp_drain2", {27'd0, gotTag[2], gotRes[2]}, {27'd0, 5'd3, 32'hB2D0_5E00});
      end

      // Flush with two ops in flight and the sink stalled; the op offered
      // in the flush cycle must be dropped as well
      step();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      setOp(32'h4020_0000, RM_RNE, 3'd0, 1'b0, 5'd10);
      step();
      setOp(32'h3F80_0000, RM_RNE, 3'd0, 1'b0, 5'd11);
      step();
      checkOutput("flush_pre_valid", 64'(out_valid), 64'd1);
      flush = 1'b1;
      setOp(32'h4000_0000, RM_RNE, 3'd0, 1'b0, 5'd12);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      sawOut = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (out_valid) sawOut = 1'b1;
         step();
      end
      checkOutput("flush_no_stale", 64'(sawOut), 64'd0);

      // Reset in the middle of a stream
      out_ready = 1'b0;
      in_valid  = 1'b1;
      setOp(32'hBFC0_0000, RM_RNE, 3'd0, 1'b1, 5'd20);
      step();
      setOp(32'h4020_0000, RM_RUP, 3'd0, 1'b0, 5'd21);
      step();
      checkOutput("rst_pre_valid", 64'(out_valid), 64'd1);
      reset = 1'b1;
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      checkOutput("rst_mid_outputs",
                  {26'd0, out_valid, out_illegal_rm, out_fflags, out_tag, out_result}, 64'd0);
      out_ready = 1'b1;
      sawOut = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (out_valid) sawOut = 1'b1;
         step();
      end
      checkOutput("rst_no_stale", 64'(sawOut), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
